// File: rtl/compare_window_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// compare_window_accumulator_pkg
// Shared definitions for the comparator result-stream accumulator:
//   - comparator op_sel codes, so producer and consumer agree on the encoding
//   - 2-bit FSM state encodings and the state enum built on them
//   - cmp_cnt_w(): width needed to hold a count of 0..max_win
// -----------------------------------------------------------------------------
package compare_window_accumulator_pkg;

    typedef enum logic [2:0] {
        OP_EQ = 3'b000,
        OP_NE = 3'b001,
        OP_LT = 3'b010,
        OP_LE = 3'b011,
        OP_GT = 3'b100,
        OP_GE = 3'b101
    } cmp_op_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ACCUM = ST_ACCUM,
        S_DONE  = ST_DONE
    } state_e;

    // Bits needed to represent every value 0..max_win inclusive.
    function automatic int cmp_cnt_w(input int max_win);
        return $clog2(max_win + 1);
    endfunction

endpackage

// File: rtl/compare_window_accumulator_cmp_window_counter.sv
// -----------------------------------------------------------------------------
// compare_window_accumulator_cmp_window_counter
// Sample index and hit counter for one accumulation window.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero index and hit count (window start)
//   inc_idx   : a sample was accepted
//   inc_hit   : the accepted sample was a true comparator result
//   len_i     : latched window length
//   idx_o     : index of the next sample to be accepted
//   hit_o     : true results accepted so far in this window
//   last_o    : the next accepted sample closes the window (idx == len-1)
// -----------------------------------------------------------------------------
module compare_window_accumulator_cmp_window_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc_idx,
    input  logic             inc_hit,
    input  logic [CNT_W-1:0] len_i,
    output logic [CNT_W-1:0] idx_o,
    output logic [CNT_W-1:0] hit_o,
    output logic             last_o
);

    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_hit;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_idx <= '0;
            r_hit <= '0;
        end else if (inc_idx) begin
            r_idx <= r_idx + CNT_W'(1);
            if (inc_hit) begin
                r_hit <= r_hit + CNT_W'(1);
            end
        end
    end

    assign idx_o  = r_idx;
    assign hit_o  = r_hit;
    // Only consulted in ACCUM, where len_i is never zero.
    assign last_o = (r_idx == (len_i - CNT_W'(1)));

endmodule

// File: rtl/compare_window_accumulator.sv
// -----------------------------------------------------------------------------
// compare_window_accumulator
// Counts true comparator results over a window of win_len accepted samples and
// presents a registered summary (hit count, any/all flags) on a valid/ready
// output. win_len above MAX_WIN is clamped to MAX_WIN; win_len = 0 produces an
// empty summary immediately.
// Optional feature macro CMP_ACC_FIRST_HIT_EN adds the index of the first true
// result of the window (first_hit_idx / first_hit_vld).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start/win_len : begin a window (IDLE, or DONE during the output handshake)
//   in_valid/in_ready/cmp_result : comparator result stream (ready in ACCUM)
//   out_valid/out_ready          : summary handshake (valid in DONE)
//   hit_count, any_hit, all_hit  : registered summary
//   busy                         : not IDLE
//   first_hit_idx, first_hit_vld : (CMP_ACC_FIRST_HIT_EN only) first true index
// -----------------------------------------------------------------------------
module compare_window_accumulator
    import compare_window_accumulator_pkg::*;
#(
    parameter int MAX_WIN = 255,
    parameter int CNT_W   = cmp_cnt_w(MAX_WIN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             cmp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic             any_hit,
    output logic             all_hit,
`ifdef CMP_ACC_FIRST_HIT_EN
    output logic [CNT_W-1:0] first_hit_idx,
    output logic             first_hit_vld,
`endif
    output logic             busy
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_start_acc;
    logic             w_accept;
    logic [CNT_W-1:0] w_len_eff;
    logic [CNT_W-1:0] w_idx;
    logic [CNT_W-1:0] w_hit;
    logic [CNT_W-1:0] w_hit_final;
    logic             w_last;

    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_hit_count;
    logic             r_any_hit;
    logic             r_all_hit;

    assign w_len_eff   = (win_len > CNT_W'(MAX_WIN)) ? CNT_W'(MAX_WIN) : win_len;
    assign w_accept    = in_valid & w_in_ready;
    // Count including the sample accepted on this edge, so the summary can
    // load on the same edge as the last accept.
    assign w_hit_final = w_hit + CNT_W'(cmp_result);

    compare_window_accumulator_cmp_window_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_start_acc),
        .inc_idx (w_accept),
        .inc_hit (w_accept & cmp_result),
        .len_i   (r_len),
        .idx_o   (w_idx),
        .hit_o   (w_hit),
        .last_o  (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = (w_len_eff == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_in_ready = 1'b1;
                if (in_valid && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    if (start) begin
                        w_start_acc = 1'b1;
                        w_state_nxt = (w_len_eff == '0) ? S_DONE : S_ACCUM;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Summary registers: cleared when a window starts, loaded on the last accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_hit_count <= '0;
            r_any_hit   <= 1'b0;
            r_all_hit   <= 1'b0;
        end else if (w_start_acc) begin
            r_len       <= w_len_eff;
            r_hit_count <= '0;
            r_any_hit   <= 1'b0;
            r_all_hit   <= 1'b0;
        end else if (w_accept && w_last) begin
            r_hit_count <= w_hit_final;
            r_any_hit   <= (w_hit_final != '0);
            r_all_hit   <= (w_hit_final == r_len) && (r_len != '0);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign hit_count = r_hit_count;
    assign any_hit   = r_any_hit;
    assign all_hit   = r_all_hit;
    assign busy      = (r_state != S_IDLE);

`ifdef CMP_ACC_FIRST_HIT_EN
    logic [CNT_W-1:0] r_first_idx;
    logic             r_first_vld;

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
        end else if (w_accept && cmp_result && !r_first_vld) begin
            r_first_idx <= w_idx;
            r_first_vld <= 1'b1;
        end
    end

    assign first_hit_idx = r_first_idx;
    assign first_hit_vld = r_first_vld;
`else
    // The sample index only feeds the first-hit logic.
    logic w_unused_idx;
    assign w_unused_idx = ^w_idx;
`endif

endmodule

// File: tb/tb_compare_window_accumulator.sv
module tb_compare_window_accumulator;

    localparam int MAX_WIN = 255;
    localparam int CNT_W   = 9;   // wide build so win_len can exceed MAX_WIN

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic             in_valid;
    logic             in_ready;
    logic             cmp_result;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] hit_count;
    logic             any_hit;
    logic             all_hit;
    logic             busy;
`ifdef CMP_ACC_FIRST_HIT_EN
    logic [CNT_W-1:0] first_hit_idx;
    logic             first_hit_vld;
`endif

    compare_window_accumulator #(
        .MAX_WIN (MAX_WIN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .win_len    (win_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cmp_result (cmp_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .hit_count  (hit_count),
        .any_hit    (any_hit),
        .all_hit    (all_hit),
`ifdef CMP_ACC_FIRST_HIT_EN
        .first_hit_idx (first_hit_idx),
        .first_hit_vld (first_hit_vld),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hit;
        int any_f;
        int all_f;
        int fidx;
        int fvld;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int h, input int a, input int al, input int fi, input int fv);
        exp_t e;
        e.hit = h; e.any_f = a; e.all_f = al; e.fidx = fi; e.fvld = fv;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one result for exactly one cycle (caller ensures ACCUM).
    task automatic send(input logic b);
        in_valid   = 1'b1;
        cmp_result = b;
        tick();
        in_valid   = 1'b0;
        cmp_result = 1'b0;
    endtask

    task automatic begin_window(input int len);
        start   = 1'b1;
        win_len = CNT_W'(len);
        tick();
        start   = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Monitor: every completed output handshake is checked against the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_summary", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_hit_count", int'(hit_count), e.hit);
                chk("sb_any_hit", int'(any_hit), e.any_f);
                chk("sb_all_hit", int'(all_hit), e.all_f);
`ifdef CMP_ACC_FIRST_HIT_EN
                chk("sb_first_hit_idx", int'(first_hit_idx), e.fidx);
                chk("sb_first_hit_vld", int'(first_hit_vld), e.fvld);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; win_len = '0;
        in_valid = 1'b0; cmp_result = 1'b0; out_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_hit_count", int'(hit_count), 0);
        chk("rst_any_all", int'({any_hit, all_hit}), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        // 1: window of 4, results 1,0,1,1
        push_exp(3, 1, 0, 0, 1);
        begin_window(4);
        chk("t1_in_ready", int'(in_ready), 1);
        chk("t1_busy", int'(busy), 1);
        send(1'b1); send(1'b0); send(1'b1);
        chk("t1_not_done_early", int'(out_valid), 0);
        send(1'b1);
        chk("t1_latency_out_valid", int'(out_valid), 1);
        chk("t1_hit_count", int'(hit_count), 3);
        handshake();
        chk("t1_idle_after", int'(busy), 0);

        // 2: backpressure; start held high during ACCUM and stalled DONE
        push_exp(3, 1, 1, 0, 1);
        begin_window(3);
        start = 1'b1; win_len = CNT_W'(7);
        send(1'b1); send(1'b1); send(1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_out_valid", int'(out_valid), 1);
            chk("t2_stall_hit_count", int'(hit_count), 3);
            chk("t2_stall_all_hit", int'(all_hit), 1);
            chk("t2_stall_in_ready", int'(in_ready), 0);
            tick();
        end
        start = 1'b0;
        handshake();
        chk("t2_idle_after", int'(busy), 0);
        chk("t2_out_valid_after", int'(out_valid), 0);

        // 3a: zero-length window
        push_exp(0, 0, 0, 0, 0);
        begin_window(0);
        chk("t3_zero_done", int'(out_valid), 1);
        chk("t3_zero_in_ready", int'(in_ready), 0);
        chk("t3_zero_hit", int'(hit_count), 0);
        handshake();

        // 3b: win_len=300 clamps to 255 samples
        push_exp(255, 1, 1, 0, 1);
        begin_window(300);
        in_valid = 1'b1; cmp_result = 1'b1;
        for (int i = 0; i < 254; i++) tick();
        chk("t3_clamp_still_accum", int'(in_ready), 1);
        chk("t3_clamp_not_done", int'(out_valid), 0);
        tick();
        in_valid = 1'b0; cmp_result = 1'b0;
        chk("t3_clamp_done", int'(out_valid), 1);
        chk("t3_clamp_hit", int'(hit_count), 255);
        handshake();

        // 4: back-to-back windows
        push_exp(1, 1, 0, 0, 1);
        begin_window(2);
        send(1'b1); send(1'b0);
        push_exp(2, 1, 1, 0, 1);
        start = 1'b1; win_len = CNT_W'(2); out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("t4_b2b_in_ready", int'(in_ready), 1);
        chk("t4_b2b_hit_cleared", int'(hit_count), 0);
        send(1'b1); send(1'b1);
        chk("t4_second_done", int'(out_valid), 1);
        handshake();

        // 5: reset mid-window, then a window of zeros
        begin_window(5);
        send(1'b1); send(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_in_ready", int'(in_ready), 0);
        chk("t5_rst_out_valid", int'(out_valid), 0);
        chk("t5_rst_hit", int'(hit_count), 0);
        push_exp(0, 0, 0, 0, 0);
        begin_window(2);
        send(1'b0); send(1'b0);
        chk("t5_done", int'(out_valid), 1);
        handshake();

        // 6: first-hit tracking (summary checked in every build)
        push_exp(2, 1, 0, 3, 1);
        begin_window(6);
        send(1'b0); send(1'b0); send(1'b0); send(1'b1); send(1'b0); send(1'b1);
        handshake();
        push_exp(0, 0, 0, 0, 0);
        begin_window(3);
        send(1'b0); send(1'b0); send(1'b0);
        handshake();

        tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
